bp_fe_queue_rollback: RTL and testbench



---
 rtl/bp_fe_queue_rollback_pkg.sv | 19 +
 rtl/bp_fe_queue_rollback_mem.sv | 24 ++
 rtl/bp_fe_queue_rollback.sv | 91 +++++++++
 tb/tb_bp_fe_queue_rollback.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bp_fe_queue_rollback_pkg.sv
// Shared FE queue types: pointer width and the wrap/index pointer struct.
package bp_fe_queue_rollback_pkg;

  localparam int unsigned fe_queue_els_gp = 8;
  localparam int unsigned ptr_width_lp    = $clog2(fe_queue_els_gp) + 1;

  typedef struct packed {
    logic                    wrap;
    logic [ptr_width_lp-2:0] idx;
  } bp_fe_queue_ptr_s;

  localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

  // Wrap and index increment together, so the pointer rolls from 2*els-1 to 0.
  function automatic bp_fe_queue_ptr_s ptr_inc(input bp_fe_queue_ptr_s p);
    return bp_fe_queue_ptr_s'(p + ptr_one_lp);
  endfunction

endpackage

// File: rtl/bp_fe_queue_rollback_mem.sv
// FE queue storage: 1R1W register file, synchronous write, asynchronous read, no reset.
module bp_fe_queue_rollback_mem
  import bp_fe_queue_rollback_pkg::*;
#(
  parameter int unsigned els_p   = fe_queue_els_gp,
  parameter int unsigned width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [$clog2(els_p)-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [$clog2(els_p)-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_rollback.sv
// FE queue producer end with speculative read (yumi), commit (deq), rewind (roll) and flush (clr).
module bp_fe_queue_rollback
  import bp_fe_queue_rollback_pkg::*;
#(
  parameter int unsigned els_p   = fe_queue_els_gp,
  parameter int unsigned width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               fe_queue_deq_i,
  input  logic               fe_queue_roll_i,
  input  logic               fe_queue_clr_i
);

  bp_fe_queue_ptr_s wptr_q, wptr_d;
  bp_fe_queue_ptr_s rptr_q, rptr_d;
  bp_fe_queue_ptr_s cptr_q, cptr_d;

  logic               empty, full;
  logic               enq, yumi_ok, deq_ok;
  logic [width_p-1:0] r_data;

  // Fullness is measured against the commit pointer so consumed-but-uncommitted entries survive.
  assign empty = (rptr_q == wptr_q);
  assign full  = (wptr_q.idx == cptr_q.idx) && (wptr_q.wrap != cptr_q.wrap);

  assign fe_queue_v_o     = ~empty;
  assign fe_queue_ready_o = ~full;

  assign enq     = fe_queue_v_i & ~full;
  assign yumi_ok = fe_queue_yumi_i & ~empty;
  assign deq_ok  = fe_queue_deq_i & (cptr_q != rptr_q);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (enq)    wptr_d = ptr_inc(wptr_q);
    if (deq_ok) cptr_d = ptr_inc(cptr_q);
    if (fe_queue_roll_i) rptr_d = cptr_d;
    else if (yumi_ok)    rptr_d = ptr_inc(rptr_q);
    if (fe_queue_clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  bp_fe_queue_rollback_mem #(
    .els_p   (els_p),
    .width_p (width_p)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq & ~fe_queue_clr_i),
    .w_addr_i (wptr_q.idx),
    .w_data_i (fe_queue_i),
    .r_addr_i (rptr_q.idx),
    .r_data_o (r_data)
  );

  // Storage is never reset, so the read data is gated while nothing is readable.
  assign fe_queue_o = empty ? '0 : r_data;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !fe_queue_clr_i) begin
      assert (!(fe_queue_yumi_i && empty));
      assert (!(fe_queue_deq_i && (cptr_q == rptr_q)));
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_queue_rollback.sv
// Bench for bp_fe_queue_rollback: directed scenarios plus random traffic against a queue model.
module tb_bp_fe_queue_rollback;

  localparam int ELS = 8;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [63:0] fe_queue_i;
  logic        fe_queue_v_i;
  logic        fe_queue_ready_o;
  logic [63:0] fe_queue_o;
  logic        fe_queue_v_o;
  logic        fe_queue_yumi_i;
  logic        fe_queue_deq_i;
  logic        fe_queue_roll_i;
  logic        fe_queue_clr_i;

  bp_fe_queue_rollback #(.els_p(ELS), .width_p(64)) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_deq_i   (fe_queue_deq_i),
    .fe_queue_roll_i  (fe_queue_roll_i),
    .fe_queue_clr_i   (fe_queue_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Model: mq holds every entry from the commit point on; rd counts how many are speculatively read.
  logic [63:0] mq[$];
  int          rd;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic bit m_v();     return rd < mq.size();  endfunction
  function automatic bit m_ready(); return mq.size() < ELS; endfunction
  function automatic logic [63:0] m_out(); return m_v() ? mq[rd] : 64'h0; endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check("v_o",     {63'b0, fe_queue_v_o},     {63'b0, m_v()});
    check("ready_o", {63'b0, fe_queue_ready_o}, {63'b0, m_ready()});
    check("data_o",  fe_queue_o,                m_out());
  endtask

  // One clock: drive inputs, update the model at the edge, compare at the falling edge.
  task automatic step(input bit enq, input logic [63:0] data, input bit yumi,
                      input bit deq, input bit roll, input bit clr);
    bit rdy;
    fe_queue_v_i    = enq;
    fe_queue_i      = data;
    fe_queue_yumi_i = yumi;
    fe_queue_deq_i  = deq;
    fe_queue_roll_i = roll;
    fe_queue_clr_i  = clr;
    @(posedge clk_i);
    rdy = m_ready();
    if (clr) begin
      mq.delete();
      rd = 0;
    end else begin
      if (deq && rd > 0) begin
        void'(mq.pop_front());
        rd--;
      end
      if (roll) rd = 0;
      else if (yumi && rd < mq.size()) rd++;
      if (enq && rdy) mq.push_back(data);
    end
    @(negedge clk_i);
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    fe_queue_deq_i  = 1'b0;
    fe_queue_roll_i = 1'b0;
    fe_queue_clr_i  = 1'b0;
    compare_model();
  endtask

  initial begin
    reset_n_i = 1'b0;
    fe_queue_i = '0; fe_queue_v_i = 0; fe_queue_yumi_i = 0;
    fe_queue_deq_i = 0; fe_queue_roll_i = 0; fe_queue_clr_i = 0;
    rd = 0;
    repeat (2) @(negedge clk_i);
    check("reset_v",     {63'b0, fe_queue_v_o},     64'd0);
    check("reset_ready", {63'b0, fe_queue_ready_o}, 64'd1);
    check("reset_data",  fe_queue_o,                64'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    compare_model();

    // Fill to capacity, reject the 9th packet, read all 8 back in order.
    for (int i = 0; i < ELS; i++) step(1, 64'hA0 + 64'(i), 0, 0, 0, 0);
    check("fill_ready", {63'b0, fe_queue_ready_o}, 64'd0);
    step(1, 64'hDEAD, 0, 0, 0, 0);
    for (int i = 0; i < ELS; i++) begin
      check("fill_order", fe_queue_o, 64'hA0 + 64'(i));
      step(0, 0, 1, 0, 0, 0);
    end
    check("fill_drained_v", {63'b0, fe_queue_v_o}, 64'd0);
    check("fill_still_full", {63'b0, fe_queue_ready_o}, 64'd0);
    step(0, 0, 0, 0, 0, 1);

    // Roll back to the commit point after one deq.
    for (int i = 0; i < 4; i++) step(1, 64'hA0 + 64'(i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 1; i < 4; i++) begin
      check("roll_replay", fe_queue_o, 64'hA0 + 64'(i));
      step(0, 0, 1, 0, 0, 0);
    end
    check("roll_drained_v", {63'b0, fe_queue_v_o}, 64'd0);
    step(0, 0, 0, 0, 0, 1);

    // Deq and roll in the same cycle land rptr on the new commit point.
    for (int i = 0; i < 3; i++) step(1, 64'hB0 + 64'(i), 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    check("deq_roll_data", fe_queue_o, 64'hB1);
    step(0, 0, 0, 0, 0, 1);

    // Clear wins over a concurrent enqueue.
    for (int i = 0; i < 5; i++) step(1, 64'hC0 + 64'(i), 0, 0, 0, 0);
    step(1, 64'h55, 0, 0, 0, 1);
    check("clr_v",     {63'b0, fe_queue_v_o},     64'd0);
    check("clr_ready", {63'b0, fe_queue_ready_o}, 64'd1);
    step(0, 0, 0, 0, 0, 0);
    check("clr_no_55", {63'b0, fe_queue_v_o}, 64'd0);

    // Streaming across two pointer wraps.
    for (int i = 0; i < 22; i++) begin
      if (fe_queue_v_o) check("wrap_order", fe_queue_o, 64'hD00 + 64'(i - 1));
      check("wrap_ready", {63'b0, fe_queue_ready_o}, 64'd1);
      step(i < 20, 64'hD00 + 64'(i), m_v(), rd > 0, 0, 0);
    end

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 60, {$urandom, $urandom},
           m_v() && ($urandom_range(0, 99) < 55),
           (rd > 0) && ($urandom_range(0, 99) < 45),
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 2);
    end

    // Asynchronous reset between edges, with data in flight.
    for (int i = 0; i < 3; i++) step(1, 64'hE0 + 64'(i), 0, 0, 0, 0);
    #2 reset_n_i = 1'b0;
    #1;
    check("areset_v",     {63'b0, fe_queue_v_o},     64'd0);
    check("areset_ready", {63'b0, fe_queue_ready_o}, 64'd1);
    check("areset_data",  fe_queue_o,                64'd0);
    mq.delete();
    rd = 0;
    #1 reset_n_i = 1'b1;
    @(negedge clk_i);
    compare_model();
    step(1, 64'hF0, 0, 0, 0, 0);
    check("post_reset_data", fe_queue_o, 64'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
